// File: rtl/store_result_checker.sv
// Store result checker: watches the data-memory write port of the pipeline,
// scores each store against a programmable table of expected words, and
// reports pass/fail/unexpected counts plus done/pass/timeout flags.
module store_result_checker #(
    parameter int unsigned NUM_CHECKS     = 8,
    parameter int unsigned BASE_ADDR      = 200,
    parameter int unsigned TIMEOUT_CYCLES = 300,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          memwrite,
    input  logic [31:0]                   dataadr,
    input  logic [31:0]                   writedata,
    input  logic                          exp_we,
    input  logic [$clog2(NUM_CHECKS)-1:0] exp_idx,
    input  logic [31:0]                   exp_data,
    input  logic                          start,
    output logic [CNT_W-1:0]              pass_count,
    output logic [CNT_W-1:0]              fail_count,
    output logic [CNT_W-1:0]              unexpected_count,
    output logic [NUM_CHECKS-1:0]         seen_mask,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout,
    output logic                          pass
);

    localparam int unsigned IDX_W = $clog2(NUM_CHECKS);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [31:0]           BASE_A   = 32'(BASE_ADDR);
    localparam logic [31:0]           END_A    = 32'(BASE_ADDR + 4 * NUM_CHECKS);
    localparam logic [CNT_W-1:0]      CNT_MAX  = '1;
    localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_CHECKS-1:0] ALL_SEEN = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:0] exp_table_q [NUM_CHECKS];

    logic        cap_vld_q, cap_vld_d;
    logic [31:0] cap_adr_q, cap_adr_d;
    logic [31:0] cap_dat_q, cap_dat_d;

    logic [CNT_W-1:0]      pass_q,  pass_d;
    logic [CNT_W-1:0]      fail_q,  fail_d;
    logic [CNT_W-1:0]      unexp_q, unexp_d;
    logic [NUM_CHECKS-1:0] mask_q,  mask_d;
    logic [TMO_W-1:0]      tmo_q,   tmo_d;
    logic                  timeout_q, timeout_d;
    logic                  busy_q,  busy_d;
    logic                  done_q,  done_d;

    logic             cap_unexp_c;
    logic [IDX_W-1:0] cap_idx_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Expected table: written only in IDLE, deliberately untouched by reset
    always_ff @(posedge clk) begin
        if (rst_n && state_q == S_IDLE && exp_we && 32'(exp_idx) < NUM_CHECKS) begin
            exp_table_q[exp_idx] <= exp_data;
        end
    end

    // Classify the captured store; unsigned compares keep wrapped addresses out
    always_comb begin
        cap_unexp_c = (cap_adr_q[1:0] != 2'b00) || (cap_adr_q < BASE_A) || (cap_adr_q >= END_A);
        cap_idx_c   = IDX_W'((cap_adr_q - BASE_A) >> 2);
    end

    // Next-state, capture and scoring logic
    always_comb begin
        state_d   = state_q;
        cap_vld_d = 1'b0;
        cap_adr_d = cap_adr_q;
        cap_dat_d = cap_dat_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        unexp_d   = unexp_q;
        mask_d    = mask_q;
        tmo_d     = tmo_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_RUN;
                    pass_d    = '0;
                    fail_d    = '0;
                    unexp_d   = '0;
                    mask_d    = '0;
                    tmo_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            S_RUN: begin
                cap_vld_d = memwrite;
                cap_adr_d = dataadr;
                cap_dat_d = writedata;
                tmo_d     = tmo_q + TMO_W'(1);
                if (cap_vld_q) begin
                    if (cap_unexp_c) begin
                        unexp_d = sat_inc(unexp_q);
                    end else if (mask_q[cap_idx_c]) begin
                        fail_d = sat_inc(fail_q);
                    end else begin
                        mask_d[cap_idx_c] = 1'b1;
                        if (cap_dat_q == exp_table_q[cap_idx_c]) begin
                            pass_d = sat_inc(pass_q);
                        end else begin
                            fail_d = sat_inc(fail_q);
                        end
                    end
                end
                // Completion uses the updated mask so done lands with the last score
                if (mask_d == ALL_SEEN) begin
                    state_d = S_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and result registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cap_vld_q <= 1'b0;
            cap_adr_q <= '0;
            cap_dat_q <= '0;
            pass_q    <= '0;
            fail_q    <= '0;
            unexp_q   <= '0;
            mask_q    <= '0;
            tmo_q     <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cap_vld_q <= cap_vld_d;
            cap_adr_q <= cap_adr_d;
            cap_dat_q <= cap_dat_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            unexp_q   <= unexp_d;
            mask_q    <= mask_d;
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign pass_count       = pass_q;
    assign fail_count       = fail_q;
    assign unexpected_count = unexp_q;
    assign seen_mask        = mask_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign timeout          = timeout_q;
    assign pass             = done_q & ~timeout_q & (fail_q == '0) & (unexp_q == '0)
                              & (pass_q == CNT_W'(NUM_CHECKS));

endmodule

// File: tb/tb_store_result_checker.sv
// Directed bench for store_result_checker: table of store sequences with
// hand-computed scores, plus timeout, saturation and mid-run reset sequences.
module tb_store_result_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        exp_we;
    logic [2:0]  exp_idx;
    logic [31:0] exp_data;
    logic        start;
    logic [7:0]  pass_count;
    logic [7:0]  fail_count;
    logic [7:0]  unexpected_count;
    logic [7:0]  seen_mask;
    logic        busy;
    logic        done;
    logic        timeout;
    logic        pass;

    int n_vec = 0;
    int n_err = 0;

    store_result_checker dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .memwrite         (memwrite),
        .dataadr          (dataadr),
        .writedata        (writedata),
        .exp_we           (exp_we),
        .exp_idx          (exp_idx),
        .exp_data         (exp_data),
        .start            (start),
        .pass_count       (pass_count),
        .fail_count       (fail_count),
        .unexpected_count (unexpected_count),
        .seen_mask        (seen_mask),
        .busy             (busy),
        .done             (done),
        .timeout          (timeout),
        .pass             (pass)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          n;
        logic [31:0] adr [12];
        logic [31:0] dat [12];
        logic [7:0]  e_pass;
        logic [7:0]  e_fail;
        logic [7:0]  e_unexp;
        logic [7:0]  e_mask;
        logic        e_passflag;
    } vec_t;

    vec_t        vecs [5];
    logic [31:0] golden [8];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        step();
        memwrite  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic add_store(input int v, input logic [31:0] a, input logic [31:0] d);
        vecs[v].adr[vecs[v].n] = a;
        vecs[v].dat[vecs[v].n] = d;
        vecs[v].n++;
    endtask

    task automatic add_good(input int v, input int first, input int last);
        for (int s = first; s <= last; s++) add_store(v, 32'(200 + 4 * s), golden[s]);
    endtask

    task automatic set_exp(input int v, input string nm, input logic [7:0] p, input logic [7:0] f,
                           input logic [7:0] u, input logic [7:0] m, input logic pf);
        vecs[v].name       = nm;
        vecs[v].e_pass     = p;
        vecs[v].e_fail     = f;
        vecs[v].e_unexp    = u;
        vecs[v].e_mask     = m;
        vecs[v].e_passflag = pf;
    endtask

    initial begin
        golden = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'h1234_5000, 32'h0001_0078};
        for (int v = 0; v < 5; v++) vecs[v].n = 0;

        add_good(0, 0, 7);
        set_exp(0, "full_pass", 8'd8, 8'd0, 8'd0, 8'hFF, 1'b1);

        add_good(1, 0, 5);
        add_store(1, 32'd224, 32'h1234_5001);
        add_good(1, 7, 7);
        set_exp(1, "mismatch", 8'd7, 8'd1, 8'd0, 8'hFF, 1'b0);

        add_store(2, 32'd300, 32'd1);
        add_store(2, 32'd196, 32'd1);
        add_store(2, 32'd202, 32'd1);
        add_good(2, 0, 7);
        set_exp(2, "stray", 8'd8, 8'd0, 8'd3, 8'hFF, 1'b0);

        add_store(3, 32'd200, 32'd1);
        add_store(3, 32'd200, 32'd1);
        add_good(3, 1, 7);
        set_exp(3, "duplicate", 8'd8, 8'd1, 8'd0, 8'hFF, 1'b0);

        add_store(4, 32'hFFFF_FFF8, 32'd1);
        add_store(4, 32'd0, 32'd1);
        add_store(4, 32'd232, 32'd1);
        add_store(4, 32'd229, 32'd1);
        add_good(4, 0, 7);
        set_exp(4, "wrap_edges", 8'd8, 8'd0, 8'd4, 8'hFF, 1'b0);

        rst_n = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
        exp_we = 1'b0; exp_idx = '0; exp_data = '0; start = 1'b0;
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;

        chk("rst_pass_count", 32'(pass_count), 32'd0);
        chk("rst_fail_count", 32'(fail_count), 32'd0);
        chk("rst_unexp_count", 32'(unexpected_count), 32'd0);
        chk("rst_seen_mask", 32'(seen_mask), 32'd0);
        chk("rst_flags", {28'd0, busy, done, timeout, pass}, 32'd0);

        for (int s = 0; s < 8; s++) begin
            exp_we   = 1'b1;
            exp_idx  = 3'(s);
            exp_data = golden[s];
            step();
        end
        exp_we = 1'b0;

        // Table-driven store sequences, each restarted from IDLE or DONE
        for (int v = 0; v < 5; v++) begin
            do_start();
            chk({vecs[v].name, "_start_clear"},
                {busy, done, pass, 5'd0, seen_mask, pass_count, fail_count | unexpected_count},
                {1'b1, 1'b0, 1'b0, 5'd0, 8'd0, 8'd0, 8'd0});
            for (int k = 0; k < vecs[v].n; k++) do_store(vecs[v].adr[k], vecs[v].dat[k]);
            chk({vecs[v].name, "_not_done_yet"}, {30'd0, busy, done}, 32'd2);
            step();
            chk({vecs[v].name, "_pass_count"}, 32'(pass_count), 32'(vecs[v].e_pass));
            chk({vecs[v].name, "_fail_count"}, 32'(fail_count), 32'(vecs[v].e_fail));
            chk({vecs[v].name, "_unexp_count"}, 32'(unexpected_count), 32'(vecs[v].e_unexp));
            chk({vecs[v].name, "_seen_mask"}, 32'(seen_mask), 32'(vecs[v].e_mask));
            chk({vecs[v].name, "_busy_done_to"}, {29'd0, busy, done, timeout}, 32'd2);
            chk({vecs[v].name, "_pass_flag"}, 32'(pass), 32'(vecs[v].e_passflag));
        end

        // Timeout: five good stores, DONE exactly 300 RUN edges after start
        do_start();
        for (int s = 0; s < 5; s++) do_store(32'(200 + 4 * s), golden[s]);
        for (int i = 0; i < 294; i++) step();
        chk("to_edge299_busy_done", {30'd0, busy, done}, 32'd2);
        step();
        chk("to_flags", {28'd0, busy, done, timeout, pass}, 32'b0110);
        chk("to_seen_mask", 32'(seen_mask), 32'h1F);
        chk("to_pass_count", 32'(pass_count), 32'd5);

        // DONE ignores the bus and holds
        do_store(32'd220, golden[5]);
        step();
        chk("done_hold_mask", 32'(seen_mask), 32'h1F);
        chk("done_hold_pass", 32'(pass_count), 32'd5);

        // Saturation: 260 stray stores must pin the counter at 255
        do_start();
        for (int i = 0; i < 260; i++) do_store(32'd300, 32'd0);
        step();
        chk("sat_unexp_count", 32'(unexpected_count), 32'd255);
        chk("sat_still_busy", 32'(busy), 32'd1);
        begin
            int guard = 0;
            while (!done && guard < 100) begin
                step();
                guard++;
            end
        end
        chk("sat_timeout_done", {30'd0, done, timeout}, 32'd3);

        // Reset mid-run; table write attempted in RUN must be ignored
        do_start();
        do_store(32'd200, golden[0]);
        do_store(32'd204, golden[1]);
        exp_we = 1'b1; exp_idx = 3'd0; exp_data = 32'hDEAD_BEEF;
        do_store(32'd208, golden[2]);
        exp_we = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_counts", {8'd0, pass_count, fail_count, unexpected_count}, 32'd0);
        chk("midrst_mask_flags", {20'd0, seen_mask, busy, done, timeout, pass}, 32'd0);
        do_start();
        for (int s = 0; s < 8; s++) do_store(32'(200 + 4 * s), golden[s]);
        step();
        chk("rerun_pass_count", 32'(pass_count), 32'd8);
        chk("rerun_pass_flag", {30'd0, done, pass}, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
